onehot_sel_sequencer: RTL and testbench

- Parametrised, registered successor to the 2-to-4 enable decoder.
- Turns a SEL_W-bit index into an OUT_N-bit one-hot select, with a valid/ready output handshake.
- Adds a sweep mode that walks the one-hot select from a first index to a last index, one accepted beat per step.
- The MXU controller uses it to drive the row/column enables for weight loading and activation injection into the PE array.

---
 rtl/onehot_sel_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_onehot_sel_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_sel_sequencer.sv
// ---------------------------------------------------------------------------
// onehot_sel_sequencer
//
// Registered index-to-one-hot select generator with a valid/ready output
// handshake and a sweep mode. The sweep mode walks the select from a first
// index to a last index, advancing one step per accepted beat. It drives the
// row/column enables of the MXU PE array.
//
// Parameters:
//   SEL_W  width of the select index (1..6)
//   OUT_N  number of one-hot outputs (2 <= OUT_N <= 2**SEL_W)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              global enable; low clears the output and aborts a sweep
//   in_valid/in_sel direct-decode request and index
//   in_ready        direct request is taken this cycle (combinational)
//   start           sweep request, honoured in IDLE
//   sweep_first/last sweep range, latched on start
//   out/out_idx     registered one-hot select and its binary index
//   out_valid       out/out_idx carry a beat
//   out_ready       consumer accepts the current beat
//   busy            sweep in progress
//   done            one-cycle pulse after the last sweep beat is accepted
//   err             one-cycle pulse on an illegal request
//   out_therm       (ONEHOT_SEL_THERMO_EN only) bits [out_idx:0] set while
//                   out_valid, registered alongside out
//
// Optional feature macro: ONEHOT_SEL_THERMO_EN
// ---------------------------------------------------------------------------
module onehot_sel_sequencer #(
    parameter int SEL_W = 2,
    parameter int OUT_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] in_sel,
    output logic             in_ready,
    input  logic             start,
    input  logic [SEL_W-1:0] sweep_first,
    input  logic [SEL_W-1:0] sweep_last,
    output logic [OUT_N-1:0] out,
    output logic [SEL_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ONEHOT_SEL_THERMO_EN
    output logic [OUT_N-1:0] out_therm,
`endif
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_FLUSH} state_t;

    // OUT_N widened by one bit so the legality compare also works when
    // OUT_N == 2**SEL_W.
    localparam logic [SEL_W:0] OUT_N_EXT = (SEL_W+1)'(OUT_N);

    function automatic logic idx_legal(input logic [SEL_W-1:0] idx);
        return {1'b0, idx} < OUT_N_EXT;
    endfunction

    function automatic logic [OUT_N-1:0] onehot_of(input logic [SEL_W-1:0] idx);
        return {{(OUT_N-1){1'b0}}, 1'b1} << idx;
    endfunction

`ifdef ONEHOT_SEL_THERMO_EN
    // (onehot << 1) - 1 sets bits [idx:0]; for idx == OUT_N-1 the shift
    // wraps to zero and the subtraction gives all ones.
    function automatic logic [OUT_N-1:0] thermo_of(input logic [SEL_W-1:0] idx);
        return (onehot_of(idx) << 1) - {{(OUT_N-1){1'b0}}, 1'b1};
    endfunction

    logic [OUT_N-1:0] therm_q;
    assign out_therm = therm_q;
`endif

    state_t           state_q;
    logic [OUT_N-1:0] out_q;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] last_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    // The output slot can take a new beat when it is empty or being drained.
    logic slot_free;
    assign slot_free = !valid_q || out_ready;

    // start has priority over a direct request in IDLE.
    assign in_ready = en && (state_q == S_IDLE) && !start && slot_free;

    always_ff @(posedge clk) begin
        // ld/clr/ld_idx are per-cycle scratch values that funnel every
        // beat load or clear through one place at the end of the block.
        logic             ld;
        logic             clr;
        logic [SEL_W-1:0] ld_idx;

        ld     = 1'b0;
        clr    = 1'b0;
        ld_idx = sweep_first;

        done_q <= 1'b0;
        err_q  <= 1'b0;

        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            last_q  <= '0;
            clr     = 1'b1;
        end else if (!en) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            clr     = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Retire a held direct beat; a new load below overrides.
                    if (valid_q && out_ready) begin
                        clr = 1'b1;
                    end
                    if (start && slot_free) begin
                        if ((sweep_first > sweep_last) || !idx_legal(sweep_last)) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= S_SWEEP;
                            busy_q  <= 1'b1;
                            last_q  <= sweep_last;
                            ld      = 1'b1;
                            ld_idx  = sweep_first;
                        end
                    end else if (in_valid && in_ready) begin
                        if (idx_legal(in_sel)) begin
                            ld     = 1'b1;
                            ld_idx = in_sel;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_SWEEP: begin
                    if (valid_q && out_ready) begin
                        if (idx_q == last_q) begin
                            state_q <= S_FLUSH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            clr     = 1'b1;
                        end else begin
                            ld     = 1'b1;
                            ld_idx = idx_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end

        if (ld) begin
            out_q   <= onehot_of(ld_idx);
            idx_q   <= ld_idx;
            valid_q <= 1'b1;
`ifdef ONEHOT_SEL_THERMO_EN
            therm_q <= thermo_of(ld_idx);
`endif
        end else if (clr) begin
            out_q   <= '0;
            valid_q <= 1'b0;
`ifdef ONEHOT_SEL_THERMO_EN
            therm_q <= '0;
`endif
        end
    end

    assign out       = out_q;
    assign out_idx   = idx_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_onehot_sel_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for onehot_sel_sequencer (SEL_W=3, OUT_N=6 so that illegal
// indices exist). Stimulus pushes expected events (beat/done/err) into a
// queue; a monitor pops and compares whenever the DUT shows an event.
// ---------------------------------------------------------------------------
module tb_onehot_sel_sequencer;
    localparam int SEL_W = 3;
    localparam int OUT_N = 6;
    localparam int K_BEAT = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic             clk = 1'b0;
    logic             rst, en, in_valid, in_ready, start;
    logic             out_valid, out_ready, busy, done, err;
    logic [SEL_W-1:0] in_sel, sweep_first, sweep_last, out_idx;
    logic [OUT_N-1:0] out;
`ifdef ONEHOT_SEL_THERMO_EN
    logic [OUT_N-1:0] out_therm;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        int kind;
        int idx;
    } ev_t;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    onehot_sel_sequencer #(.SEL_W(SEL_W), .OUT_N(OUT_N)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_sel(in_sel), .in_ready(in_ready),
        .start(start), .sweep_first(sweep_first), .sweep_last(sweep_last),
        .out(out), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
`ifdef ONEHOT_SEL_THERMO_EN
        .out_therm(out_therm),
`endif
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each request should produce, in order.
    function automatic void push(input int kind, input int idx);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        exp_q.push_back(e);
    endfunction

    function automatic void push_direct(input int s);
        if (s < OUT_N) push(K_BEAT, s);
        else           push(K_ERR, 0);
    endfunction

    function automatic void push_sweep(input int f, input int l);
        if (f > l || l >= OUT_N) begin
            push(K_ERR, 0);
        end else begin
            for (int i = f; i <= l; i++) push(K_BEAT, i);
            push(K_DONE, 0);
        end
    endfunction

    // Monitor: invariants every cycle, event scoreboard on beat/done/err.
    initial begin : monitor
        ev_t         e;
        int          kind;
        logic        beat;
        logic [63:0] therm_exp;
        forever begin
            @(negedge clk);
            chk("inv_nonzero_iff_valid", 64'(out != '0), 64'(out_valid));
            chk("inv_onehot", 64'($countones(out) <= 1), 64'd1);
`ifdef ONEHOT_SEL_THERMO_EN
            therm_exp = out_valid ? ((64'd1 << (int'(out_idx) + 1)) - 64'd1) : 64'd0;
            chk("therm", 64'(out_therm), therm_exp);
`endif
            beat = out_valid && out_ready;
            if (beat || done || err) begin
                kind = beat ? K_BEAT : (done ? K_DONE : K_ERR);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 64'({beat, done, err}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 64'(kind), 64'(e.kind));
                    if (kind == K_BEAT) begin
                        chk("beat_idx", 64'(out_idx), 64'(e.idx));
                        chk("beat_out", 64'(out), 64'd1 << e.idx);
                    end else begin
                        chk("event_busy", 64'(busy), 64'd0);
                        chk("event_valid", 64'(out_valid), 64'd0);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_direct();
        int s;
        bit took;
        s = $urandom_range(0, 2**SEL_W - 1);
        in_valid = 1'b1;
        in_sel   = SEL_W'(s);
        took     = 1'b0;
        for (int n = 0; n < 200 && !took; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            // start in SWEEP/FLUSH must be ignored
            start = (busy || done) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            took = in_valid && in_ready;
            cyc();
        end
        chk("direct_accepted", 64'(took), 64'd1);
        if (took) push_direct(s);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_sweep();
        int f, l;
        bit idle;
        idle = !busy && !done && !out_valid;
        for (int n = 0; n < 200 && !idle; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            start     = (busy || done) ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc();
            idle = !busy && !done && !out_valid;
        end
        chk("sweep_idle_reached", 64'(idle), 64'd1);
        l = $urandom_range(0, 2**SEL_W - 1);
        f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2**SEL_W - 1) : $urandom_range(0, l);
        sweep_first = SEL_W'(f);
        sweep_last  = SEL_W'(l);
        start       = 1'b1;
        out_ready   = ($urandom_range(0, 3) != 0);
        if (idle) push_sweep(f, l);
        cyc();
        start = 1'b0;
    endtask

    task automatic do_abort(input bit use_rst);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        start     = 1'b0;
        if (use_rst) rst = 1'b1;
        else         en  = 1'b0;
        cyc();
        exp_q.delete();
        chk("abort_out", 64'(out), 64'd0);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        if (use_rst) begin
            chk("rst_idx", 64'(out_idx), 64'd0);
            chk("rst_err", 64'(err), 64'd0);
        end
        rst = 1'b0;
        en  = 1'b1;
        cyc();
        chk("abort_no_done", 64'(done), 64'd0);
    endtask

    initial begin : driver
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_sel = '0; start = 1'b0;
        sweep_first = '0; sweep_last = '0; out_ready = 1'b0;
        cyc();
        cyc();
        chk("reset_out", 64'(out), 64'd0);
        chk("reset_idx", 64'(out_idx), 64'd0);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        cyc();

        // Direct decode of index 2, one beat, latency 1.
        in_valid = 1'b1; in_sel = 3'd2;
        #1 chk("direct_in_ready", 64'(in_ready), 64'd1);
        push_direct(2);
        cyc();
        in_valid = 1'b0;
        chk("direct_out", 64'(out), 64'b000100);
        chk("direct_valid", 64'(out_valid), 64'd1);
        cyc();
        chk("direct_one_beat", 64'(out_valid), 64'd0);

        // Sweep 1..3 at full rate, then done.
        sweep_first = 3'd1; sweep_last = 3'd3; start = 1'b1;
        push_sweep(1, 3);
        cyc();
        start = 1'b0;
        chk("sweep_busy", 64'(busy), 64'd1);
        chk("sweep_b0", 64'(out), 64'b000010);
        cyc(); chk("sweep_b1", 64'(out), 64'b000100);
        cyc(); chk("sweep_b2", 64'(out), 64'b001000);
        cyc();
        chk("sweep_done", 64'(done), 64'd1);
        chk("sweep_done_out", 64'(out), 64'd0);
        chk("sweep_done_busy", 64'(busy), 64'd0);
        cyc(); chk("sweep_done_pulse", 64'(done), 64'd0);

        // Backpressure on the second beat of a 0..3 sweep.
        sweep_first = 3'd0; sweep_last = 3'd3; start = 1'b1;
        push_sweep(0, 3);
        cyc();
        start = 1'b0;
        chk("bp_b0", 64'(out), 64'b000001);
        cyc(); chk("bp_b1", 64'(out), 64'b000010);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold", 64'(out), 64'b000010);
        end
        out_ready = 1'b1;
        cyc(); chk("bp_b2", 64'(out), 64'b000100);
        cyc(); chk("bp_b3", 64'(out), 64'b001000);
        cyc(); chk("bp_done", 64'(done), 64'd1);
        cyc();

        // Illegal direct index.
        in_valid = 1'b1; in_sel = 3'd7;
        push_direct(7);
        cyc();
        in_valid = 1'b0;
        chk("ill_dir_err", 64'(err), 64'd1);
        chk("ill_dir_valid", 64'(out_valid), 64'd0);
        cyc(); chk("ill_dir_err_pulse", 64'(err), 64'd0);

        // Illegal sweep ranges: first > last, last >= OUT_N.
        sweep_first = 3'd2; sweep_last = 3'd1; start = 1'b1;
        push_sweep(2, 1);
        cyc();
        start = 1'b0;
        chk("ill_sw_err", 64'(err), 64'd1);
        chk("ill_sw_busy", 64'(busy), 64'd0);
        cyc(); chk("ill_sw_err_pulse", 64'(err), 64'd0);
        sweep_first = 3'd0; sweep_last = 3'd6; start = 1'b1;
        push_sweep(0, 6);
        cyc();
        start = 1'b0;
        chk("ill_last_err", 64'(err), 64'd1);
        chk("ill_last_valid", 64'(out_valid), 64'd0);
        cyc();

        // start and in_valid together: start wins, single-entry sweep.
        sweep_first = 3'd0; sweep_last = 3'd0; start = 1'b1;
        in_valid = 1'b1; in_sel = 3'd1;
        #1 chk("simul_in_ready", 64'(in_ready), 64'd0);
        push_sweep(0, 0);
        cyc();
        start = 1'b0;
        chk("single_out", 64'(out), 64'b000001);
        chk("single_busy", 64'(busy), 64'd1);
        cyc(); chk("single_done", 64'(done), 64'd1);
        cyc(); chk("held_in_ready", 64'(in_ready), 64'd1);
        push_direct(1);
        cyc();
        in_valid = 1'b0;
        chk("held_out", 64'(out), 64'b000010);
        cyc();

`ifdef ONEHOT_SEL_THERMO_EN
        sweep_first = 3'd0; sweep_last = 3'd2; start = 1'b1;
        push_sweep(0, 2);
        cyc();
        start = 1'b0;
        chk("therm_b0", 64'(out_therm), 64'b000001);
        cyc(); chk("therm_b1", 64'(out_therm), 64'b000011);
        cyc(); chk("therm_b2", 64'(out_therm), 64'b000111);
        cyc(); cyc();
`endif

        // Abort at the second beat via en, then via rst.
        for (int k = 0; k < 2; k++) begin
            sweep_first = 3'd0; sweep_last = 3'd3; start = 1'b1; out_ready = 1'b1;
            push_sweep(0, 3);
            cyc();
            start = 1'b0;
            cyc();
            chk("abort_second_beat", 64'(out), 64'b000010);
            do_abort(k == 1);
        end

        // Randomized mix.
        for (int t = 0; t < 250; t++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r < 19)      do_direct();
            else if (r < 38) do_sweep();
            else             do_abort(r == 39);
        end

        out_ready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) cyc();
        cyc();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
